// File: rtl/uart_rx_ovs.sv
// Purpose: 16x-oversampled UART receiver with 5-8 data bits, even/odd/mark parity, 1-2 stop bits, break detection.
// Latency: rx_valid rises one clk after tick 9 of the final stop bit (plus 2 clk of line synchroniser).
// Backpressure: one-deep holding register; a frame completing while held and not accepted is dropped with an overrun pulse.
module uart_rx_ovs #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int OVS       = 16,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_serial,
  input  logic [15:0]       baud_divisor,
  input  logic [1:0]        data_len,
  input  logic [1:0]        parity_sel,
  input  logic              stop_sel,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun_err,
  output logic              rx_busy
);

  // The datapath below is hard-wired for 16 ticks per bit and an 8-bit data register.
  if (OVS != 16 || DATA_W != 8 || CLK_FREQ < BAUD_RATE * OVS) begin : g_cfg_chk
    $error("uart_rx_ovs: unsupported parameter set");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP1     = 3'd4;
  localparam logic [2:0] S_STOP2     = 3'd5;
  localparam logic [2:0] S_WAIT_HIGH = 3'd6;

  localparam logic [3:0] T_S7  = 4'(OVS / 2 - 1);
  localparam logic [3:0] T_S8  = 4'(OVS / 2);
  localparam logic [3:0] T_S9  = 4'(OVS / 2 + 1);
  localparam logic [3:0] T_END = 4'(OVS - 1);

  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] div_cnt, div_eff;
  logic        tick;
  logic [2:0]  state;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic        s7, s8, maj;
  logic        mid_tick, end_tick;
  logic [1:0]  len_l, par_l;
  logic        stop_l;
  logic [7:0]  shift_dat;
  logic        par_acc, par_bad, stop_bad, all_zero;
  logic        exp_par;
  logic        done;
  logic [7:0]  pend_dat;
  logic        pend_pe, pend_fe, pend_bd;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_serial;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Free-running oversample tick generator; a zero divisor behaves as divide-by-one.
  assign div_eff = (baud_divisor == 16'd0) ? 16'd1 : baud_divisor;
  assign tick    = (div_cnt >= div_eff - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt <= 16'd0;
    else        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
  end

  // Majority of the tick-7 and tick-8 samples with the live tick-9 sample.
  assign maj      = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
  assign mid_tick = tick && (tick_cnt == T_S9);
  assign end_tick = tick && (tick_cnt == T_END);

  always_comb begin
    exp_par = 1'b0;
    case (par_l)
      2'b01:   exp_par = par_acc;
      2'b10:   exp_par = ~par_acc;
      2'b11:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Receive FSM: bit timing, sampling, data assembly and frame qualification.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      s7        <= 1'b0;
      s8        <= 1'b0;
      len_l     <= 2'd0;
      par_l     <= 2'd0;
      stop_l    <= 1'b0;
      shift_dat <= 8'd0;
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
      stop_bad  <= 1'b0;
      all_zero  <= 1'b0;
      done      <= 1'b0;
      pend_dat  <= 8'd0;
      pend_pe   <= 1'b0;
      pend_fe   <= 1'b0;
      pend_bd   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick && state != S_IDLE && state != S_WAIT_HIGH) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == T_S7) s7 <= rx_s2;
        if (tick_cnt == T_S8) s8 <= rx_s2;
      end
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            state     <= S_START;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            len_l     <= data_len;
            par_l     <= parity_sel;
            stop_l    <= stop_sel;
            shift_dat <= 8'd0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
            all_zero  <= 1'b1;
          end
        end
        S_START: begin
          if (mid_tick && maj) state <= S_IDLE;
          else if (end_tick)   state <= S_DATA;
        end
        S_DATA: begin
          if (mid_tick) begin
            shift_dat[bit_cnt] <= maj;
            par_acc            <= par_acc ^ maj;
            if (maj) all_zero  <= 1'b0;
          end
          if (end_tick) begin
            if (bit_cnt == 3'd4 + {1'b0, len_l}) state <= (par_l != 2'b00) ? S_PARITY : S_STOP1;
            else                                 bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (mid_tick) begin
            par_bad <= (maj != exp_par);
            if (maj) all_zero <= 1'b0;
          end
          if (end_tick) state <= S_STOP1;
        end
        S_STOP1: begin
          if (mid_tick) begin
            if (all_zero && !maj) begin
              // Line held low through the whole frame: report a break and wait for idle.
              done     <= 1'b1;
              pend_dat <= 8'd0;
              pend_pe  <= 1'b0;
              pend_fe  <= 1'b1;
              pend_bd  <= 1'b1;
              state    <= S_WAIT_HIGH;
            end else if (!stop_l) begin
              done     <= 1'b1;
              pend_dat <= shift_dat;
              pend_pe  <= par_bad;
              pend_fe  <= ~maj;
              pend_bd  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              stop_bad <= ~maj;
            end
          end else if (end_tick && stop_l) begin
            state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (mid_tick) begin
            done     <= 1'b1;
            pend_dat <= shift_dat;
            pend_pe  <= par_bad;
            pend_fe  <= stop_bad | ~maj;
            pend_bd  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s2) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != S_IDLE);

  // Holding register toward the consumer with overrun detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= pend_dat;
          rx_valid   <= 1'b1;
          parity_err <= pend_pe;
          frame_err  <= pend_fe;
          break_det  <= pend_bd;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        break_det  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Purpose: directed bench for uart_rx_ovs at baud_divisor=4 (64 clk per bit).
// Latency: frames are checked after their stop bits plus idle time.
// Backpressure: rx_ready is held high except in the overrun scenario.
module tb_uart_rx_ovs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_serial = 1'b1;
  logic [15:0] baud_divisor = 16'd4;
  logic [1:0]  data_len = 2'b11;
  logic [1:0]  parity_sel = 2'b00;
  logic        stop_sel = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state: accepted frames as {break, frame_err, parity_err, data}.
  logic [10:0] cap_q[$];
  int          vld_cycles = 0;
  int          ovr_cycles = 0;

  uart_rx_ovs dut (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .baud_divisor(baud_divisor),
    .data_len    (data_len),
    .parity_sel  (parity_sel),
    .stop_sel    (stop_sel),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .break_det   (break_det),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) vld_cycles++;
    if (overrun_err === 1'b1) ovr_cycles++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1)
      cap_q.push_back({break_det, frame_err, parity_err, rx_data});
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic b);
    rx_serial = b;
    wait_clk(64);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic [1:0] psel,
                            input logic pbit, input logic two_stop, input logic stop2_val);
    logic [7:0] dv;
    dv         = d;
    data_len   = 2'(nbits - 5);
    parity_sel = psel;
    stop_sel   = two_stop;
    line_bit(1'b0);
    for (int i = 0; i < nbits; i++) line_bit(dv[i]);
    if (psel != 2'b00) line_bit(pbit);
    line_bit(1'b1);
    if (two_stop) line_bit(stop2_val);
  endtask

  task automatic pop_frame(output logic [10:0] c);
    if (cap_q.size() > 0) c = cap_q.pop_front();
    else                  c = 'x;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    wait_clk(5);
    vectors++;
    if ({rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, want 000000",
               {rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy});
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h, want 00", rx_data);
    end
    reset = 1'b1;
    wait_clk(100);
    vectors++;
    if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: valid=%b busy=%b, want 0 0", rx_valid, rx_busy);
    end
  endtask

  task automatic test_8n1;
    logic [10:0] c;
    int v0;
    cap_q.delete();
    v0 = vld_cycles;
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_clk(128);
    vectors++;
    if (cap_q.size() !== 1) begin
      miscompares++;
      $display("FAIL 8n1_count: got %0d frames, want 1", cap_q.size());
    end
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'hA5}) begin
      miscompares++;
      $display("FAIL 8n1_frame: got %h, want %h", c, {3'b000, 8'hA5});
    end
    vectors++;
    if (vld_cycles - v0 !== 1) begin
      miscompares++;
      $display("FAIL 8n1_valid_width: got %0d cycles, want 1", vld_cycles - v0);
    end
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL 8n1_busy: got %b, want 0", rx_busy);
    end
  endtask

  task automatic test_parity;
    logic [10:0] c;
    cap_q.delete();
    send_frame(8'h3C, 7, 2'b01, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 7, 2'b01, 1'b1, 1'b0, 1'b1);
    wait_clk(128);
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'h3C}) begin
      miscompares++;
      $display("FAIL 7e1_good: got %h, want %h", c, {3'b000, 8'h3C});
    end
    pop_frame(c);
    vectors++;
    if (c !== {3'b001, 8'h3C}) begin
      miscompares++;
      $display("FAIL 7e1_bad_parity: got %h, want %h", c, {3'b001, 8'h3C});
    end
  endtask

  task automatic test_stop2_err;
    logic [10:0] c;
    cap_q.delete();
    // 0x15 in 5 bits has three ones, so odd parity bit is 0.
    send_frame(8'h15, 5, 2'b10, 1'b0, 1'b1, 1'b0);
    rx_serial = 1'b1;
    wait_clk(128);
    vectors++;
    if (cap_q.size() !== 1) begin
      miscompares++;
      $display("FAIL 5o2_count: got %0d frames, want 1", cap_q.size());
    end
    pop_frame(c);
    vectors++;
    if (c !== {3'b010, 8'h15}) begin
      miscompares++;
      $display("FAIL 5o2_frame: got %h, want %h", c, {3'b010, 8'h15});
    end
  endtask

  task automatic test_break;
    logic [10:0] c;
    cap_q.delete();
    data_len = 2'b11; parity_sel = 2'b00; stop_sel = 1'b0;
    rx_serial = 1'b0;
    wait_clk(11 * 64);
    vectors++;
    if (cap_q.size() !== 1) begin
      miscompares++;
      $display("FAIL break_count_low: got %0d frames, want 1", cap_q.size());
    end
    vectors++;
    if (rx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL break_wait_high_busy: got %b, want 1", rx_busy);
    end
    wait_clk(64);
    rx_serial = 1'b1;
    wait_clk(3 * 64);
    pop_frame(c);
    vectors++;
    if (c !== {3'b110, 8'h00}) begin
      miscompares++;
      $display("FAIL break_frame: got %h, want %h", c, {3'b110, 8'h00});
    end
    vectors++;
    if (cap_q.size() !== 0 || rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL break_after: extra=%0d busy=%b, want 0 0", cap_q.size(), rx_busy);
    end
  endtask

  task automatic test_glitch;
    logic seen_busy;
    cap_q.delete();
    rx_serial = 1'b0;
    wait_clk(10);
    seen_busy = rx_busy;
    wait_clk(10);
    rx_serial = 1'b1;
    wait_clk(100);
    vectors++;
    if (seen_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_start_busy: got %b, want 1", seen_busy);
    end
    vectors++;
    if (rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_return: got %b, want 0", rx_busy);
    end
    vectors++;
    if (cap_q.size() !== 0 || rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_no_frame: frames=%0d valid=%b, want 0 0", cap_q.size(), rx_valid);
    end
  endtask

  task automatic test_overrun;
    logic [10:0] c;
    int o0;
    cap_q.delete();
    rx_ready = 1'b0;
    o0 = ovr_cycles;
    send_frame(8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    line_bit(1'b1);
    send_frame(8'h22, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_clk(128);
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_hold: valid=%b data=%h, want 1 11", rx_valid, rx_data);
    end
    vectors++;
    if (ovr_cycles - o0 !== 1) begin
      miscompares++;
      $display("FAIL overrun_pulse: got %0d cycles, want 1", ovr_cycles - o0);
    end
    rx_ready = 1'b1;
    wait_clk(1);
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_accept_clear: got %b, want 0", rx_valid);
    end
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'h11}) begin
      miscompares++;
      $display("FAIL overrun_accepted: got %h, want %h", c, {3'b000, 8'h11});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] c;
    logic [7:0]  d;
    cap_q.delete();
    d = 8'h5A;
    data_len = 2'b11; parity_sel = 2'b00; stop_sel = 1'b0;
    line_bit(1'b0);
    for (int i = 0; i < 3; i++) line_bit(d[i]);
    rx_serial = d[3];
    wait_clk(30);
    reset = 1'b0;
    wait_clk(3);
    vectors++;
    if ({rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy} !== 14'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: data=%h flags=%b, want 00 000000", rx_data,
               {rx_valid, parity_err, frame_err, break_det, overrun_err, rx_busy});
    end
    reset = 1'b1;
    rx_serial = 1'b1;
    wait_clk(12 * 64);
    vectors++;
    if (cap_q.size() !== 0 || rx_valid !== 1'b0 || rx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_no_frame: frames=%0d valid=%b busy=%b, want 0 0 0",
               cap_q.size(), rx_valid, rx_busy);
    end
    send_frame(8'hC3, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    wait_clk(128);
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'hC3}) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got %h, want %h", c, {3'b000, 8'hC3});
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] c;
    cap_q.delete();
    send_frame(8'h81, 8, 2'b00, 1'b0, 1'b0, 1'b1);
    send_frame(8'h7E, 8, 2'b11, 1'b1, 1'b0, 1'b1);
    wait_clk(128);
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'h81}) begin
      miscompares++;
      $display("FAIL b2b_first: got %h, want %h", c, {3'b000, 8'h81});
    end
    pop_frame(c);
    vectors++;
    if (c !== {3'b000, 8'h7E}) begin
      miscompares++;
      $display("FAIL b2b_second_mark: got %h, want %h", c, {3'b000, 8'h7E});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2_err();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
